// File: rtl/booth_pkg.sv
// Shared types and arithmetic helpers for the Booth product accumulator.
package booth_pkg;

  typedef enum logic {ACCUM, DONE} state_t;

  localparam int BOOTH_PROD_W = 16;
  localparam int SAT_MAX_W    = 64;

  typedef logic signed [SAT_MAX_W-1:0] wide_t;

  // Operands arrive sign-extended from w bits, so their sum cannot overflow 64 bits.
  // The result is {ovf, sum}, with sum sign-extended from w bits.
  function automatic logic [SAT_MAX_W:0] sat_add(input wide_t a, input wide_t b,
                                                 input int unsigned w, input logic sat);
    wide_t sum;
    wide_t max_v;
    wide_t min_v;
    wide_t wrap;
    wide_t res;
    logic  ovf;
    sum   = a + b;
    max_v = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    min_v = -max_v - wide_t'(1);
    ovf   = (sum > max_v) || (sum < min_v);
    wrap  = (sum <<< (SAT_MAX_W - w)) >>> (SAT_MAX_W - w);
    if (!ovf)    res = sum;
    else if (sat) res = sum[SAT_MAX_W-1] ? min_v : max_v;
    else         res = wrap;
    return {ovf, res};
  endfunction

endpackage

// File: rtl/booth_sat_add.sv
// Combinational accumulate step: sign-extend the product, add, and clamp or wrap on overflow.
module booth_sat_add
  import booth_pkg::*;
#(
  parameter int PROD_W = BOOTH_PROD_W,
  parameter int ACC_W  = 24,
  parameter int SAT    = 1
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic signed [PROD_W-1:0] prod_i,
  output logic signed [ACC_W-1:0]  sum_o,
  output logic                     ovf_o
);

  wide_t                a_ext;
  wide_t                b_ext;
  logic [SAT_MAX_W:0]   res;
  logic                 res_unused;

  assign a_ext = wide_t'(acc_i);
  assign b_ext = wide_t'(prod_i);
  assign res   = sat_add(a_ext, b_ext, ACC_W, SAT != 0);

  assign ovf_o = res[SAT_MAX_W];
  assign sum_o = res[ACC_W-1:0];
  // Upper sum bits are only the sign extension of sum_o.
  assign res_unused = ^res[SAT_MAX_W-1:ACC_W];

endmodule

// File: rtl/booth_accum.sv
// Sums N_TERMS signed Booth products and hands the result downstream over valid/ready.
module booth_accum
  import booth_pkg::*;
#(
  parameter int PROD_W  = BOOTH_PROD_W,
  parameter int ACC_W   = 24,
  parameter int N_TERMS = 4,
  parameter int SAT     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic signed [PROD_W-1:0] prod_in,
  input  logic                     prod_valid,
  output logic                     prod_ready,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic                     acc_valid,
  input  logic                     acc_ready,
  output logic                     ovf,
  output logic [7:0]               term_cnt
);

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic [7:0]              cnt_q, cnt_d;
  logic signed [ACC_W-1:0] sum;
  logic                    add_ovf;

  booth_sat_add #(.PROD_W(PROD_W), .ACC_W(ACC_W), .SAT(SAT)) u_add (
    .acc_i  (acc_q),
    .prod_i (prod_in),
    .sum_o  (sum),
    .ovf_o  (add_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = ACCUM;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ACCUM: if (prod_valid) begin
          acc_d = sum;
          ovf_d = ovf_q | add_ovf;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'(N_TERMS - 1)) state_d = DONE;
        end
        DONE: if (acc_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  assign prod_ready = (state_q == ACCUM);
  assign acc_valid  = (state_q == DONE);
  assign acc_out    = acc_q;
  assign ovf        = ovf_q;
  assign term_cnt   = cnt_q;

endmodule

// File: tb/tb_booth_accum.sv
// Directed bench for booth_accum: default 24-bit build plus 16-bit saturating and wrapping builds.
module tb_booth_accum;

  logic               clk = 1'b0;
  logic               rst, clr;
  logic signed [15:0] prod_in;
  logic               prod_valid, prod_ready, acc_valid, acc_ready, ovf;
  logic signed [23:0] acc_out;
  logic [7:0]         term_cnt;

  logic signed [15:0] p16_in;
  logic               p16_valid;
  logic               s_ready, s_valid, s_ovf, w_ready, w_valid, w_ovf;
  logic signed [15:0] s_out, w_out;
  logic [7:0]         s_cnt, w_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  booth_accum u_dut (
    .clk(clk), .rst(rst), .clr(clr), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(prod_ready), .acc_out(acc_out), .acc_valid(acc_valid),
    .acc_ready(acc_ready), .ovf(ovf), .term_cnt(term_cnt)
  );

  booth_accum #(.ACC_W(16), .SAT(1)) u_sat16 (
    .clk(clk), .rst(rst), .clr(1'b0), .prod_in(p16_in), .prod_valid(p16_valid),
    .prod_ready(s_ready), .acc_out(s_out), .acc_valid(s_valid),
    .acc_ready(1'b0), .ovf(s_ovf), .term_cnt(s_cnt)
  );

  booth_accum #(.ACC_W(16), .SAT(0)) u_wrap16 (
    .clk(clk), .rst(rst), .clr(1'b0), .prod_in(p16_in), .prod_valid(p16_valid),
    .prod_ready(w_ready), .acc_out(w_out), .acc_valid(w_valid),
    .acc_ready(1'b0), .ovf(w_ovf), .term_cnt(w_cnt)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one product on the main DUT and return at the negedge after it is sampled.
  task automatic feed(input int v);
    prod_in    = 16'(v);
    prod_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic feed16(input int v);
    p16_in    = 16'(v);
    p16_valid = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; prod_in = '0; prod_valid = 1'b0; acc_ready = 1'b1;
    p16_in = '0; p16_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_acc_valid", 32'(acc_valid), 0);
    chk("rst_acc_out", 32'(acc_out), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_term_cnt", 32'(term_cnt), 0);
    chk("rst_prod_ready", 32'(prod_ready), 1);

    feed(100); feed(-50); feed(1000);
    chk("basic_pre_valid", 32'(acc_valid), 0);
    chk("basic_pre_cnt", 32'(term_cnt), 3);
    feed(7);
    prod_valid = 1'b0;
    chk("basic_valid", 32'(acc_valid), 1);
    chk("basic_sum", 32'(acc_out), 1057);
    chk("basic_ovf", 32'(ovf), 0);
    chk("basic_cnt", 32'(term_cnt), 4);
    chk("basic_ready_low", 32'(prod_ready), 0);
    @(negedge clk);
    chk("basic_ready_back", 32'(prod_ready), 1);
    chk("basic_valid_drop", 32'(acc_valid), 0);
    chk("basic_cnt_zero", 32'(term_cnt), 0);

    feed(16384); feed(16384); feed(-16256); feed(-16256);
    prod_valid = 1'b0;
    chk("ext_valid", 32'(acc_valid), 1);
    chk("ext_sum", 32'(acc_out), 256);
    chk("ext_ovf", 32'(ovf), 0);
    @(negedge clk);

    feed16(16384); feed16(16384); feed16(16384); feed16(16384);
    p16_valid = 1'b0;
    chk("sat16_valid", 32'(s_valid), 1);
    chk("sat16_sum", 32'(s_out), 32767);
    chk("sat16_ovf", 32'(s_ovf), 1);
    chk("wrap16_sum", 32'(w_out), 0);
    chk("wrap16_ovf", 32'(w_ovf), 1);

    acc_ready = 1'b0;
    feed(10); feed(20); feed(30); feed(40);
    prod_in = 16'sd99;
    for (int i = 0; i < 5; i++) begin
      chk("bp_sum_hold", 32'(acc_out), 100);
      chk("bp_ready_low", 32'(prod_ready), 0);
      chk("bp_cnt_hold", 32'(term_cnt), 4);
      @(negedge clk);
    end
    acc_ready = 1'b1;
    @(negedge clk);
    chk("bp_handoff_sum", 32'(acc_out), 0);
    chk("bp_handoff_valid", 32'(acc_valid), 0);
    @(negedge clk);
    prod_valid = 1'b0;
    chk("bp_first_99", 32'(acc_out), 99);
    chk("bp_first_cnt", 32'(term_cnt), 1);

    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr0_cnt", 32'(term_cnt), 0);
    feed(5); feed(6);
    chk("clr_partial", 32'(acc_out), 11);
    clr = 1'b1; prod_in = 16'sd77;
    @(negedge clk);
    clr = 1'b0; prod_valid = 1'b0;
    chk("clr_cnt", 32'(term_cnt), 0);
    chk("clr_acc", 32'(acc_out), 0);
    chk("clr_no_valid", 32'(acc_valid), 0);
    feed(1); feed(2); feed(3); feed(4);
    prod_valid = 1'b0;
    chk("post_clr_valid", 32'(acc_valid), 1);
    chk("post_clr_sum", 32'(acc_out), 10);
    @(negedge clk);

    acc_ready = 1'b0;
    feed(100); feed(100); feed(100); feed(200);
    prod_valid = 1'b0;
    chk("rst_done_sum", 32'(acc_out), 500);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_done_valid", 32'(acc_valid), 0);
    chk("rst_done_acc", 32'(acc_out), 0);
    chk("rst_done_ovf", 32'(ovf), 0);
    chk("rst_done_ready", 32'(prod_ready), 1);
    chk("rst_done_cnt", 32'(term_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
